// File: rtl/frame_sampler.sv
// -----------------------------------------------------------------------------
// frame_sampler
//
// Sequential decimating sampler. It reduces a flat frame of INPUT_COUNT words
// to OUTPUT_COUNT words, where output word i is taken from frame word
// floor(i*INPUT_COUNT/OUTPUT_COUNT). One output slot is written per clock.
// The source index is stepped by a quotient/remainder accumulator, so no
// divider is needed at run time.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - asynchronous, active-high reset
//   start        - single-cycle request, honoured only while idle
//   frame_flat   - source frame, word k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   sampled_flat - registered result vector, same packing
//   busy         - high while slots are being written
//   done         - one-cycle pulse after the last slot has been written
//
// The frame is read live; the producer must hold frame_flat stable while busy.
// -----------------------------------------------------------------------------
module frame_sampler #(
    parameter int INPUT_COUNT  = 784,
    parameter int OUTPUT_COUNT = 196,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [DATA_WIDTH*INPUT_COUNT-1:0]  frame_flat,
    output logic [DATA_WIDTH*OUTPUT_COUNT-1:0] sampled_flat,
    output logic                               busy,
    output logic                               done
);

    // Integer step of the source index and the fractional part carried
    // in units of 1/OUTPUT_COUNT.
    localparam int Q = INPUT_COUNT / OUTPUT_COUNT;
    localparam int R = INPUT_COUNT % OUTPUT_COUNT;

    localparam int IDX_W = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
    localparam int SRC_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
    // rem + R can reach 2*OUTPUT_COUNT-2, hence the extra bit.
    localparam int REM_W = $clog2(OUTPUT_COUNT) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_COUNT - 1);
    localparam logic [SRC_W-1:0] Q_STEP   = SRC_W'(Q);
    localparam logic [REM_W-1:0] R_STEP   = REM_W'(R);
    localparam logic [REM_W-1:0] OUT_CNT  = REM_W'(OUTPUT_COUNT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0] out_idx;
    logic [SRC_W-1:0] src;
    logic [REM_W-1:0] rem;

    logic load;
    logic write;
    logic last;

    logic [REM_W-1:0] rem_sum;
    logic             rem_wrap;
    logic [REM_W-1:0] rem_next;
    logic [SRC_W-1:0] src_next;

    logic [INPUT_COUNT-1:0][DATA_WIDTH-1:0]  frame_words;
    logic [OUTPUT_COUNT-1:0][DATA_WIDTH-1:0] sampled_words;

    assign frame_words  = frame_flat;
    assign sampled_flat = sampled_words;
    assign busy         = (state_q == RUN);

    // Next-state logic: a start is only looked at while idle, and the run
    // ends on the cycle that writes the final slot.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        write   = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                write = 1'b1;
                if (out_idx == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Source index stepping: add Q to src and R to rem; whenever the
    // remainder reaches OUTPUT_COUNT it carries one into src.
    always_comb begin
        rem_sum  = rem + R_STEP;
        rem_wrap = (rem_sum >= OUT_CNT);
        rem_next = rem_wrap ? (rem_sum - OUT_CNT) : rem_sum;
        src_next = src + Q_STEP + SRC_W'(rem_wrap);
    end

    // State, counters and result registers. The counters are not advanced
    // after the last slot so src never steps past the end of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            done          <= 1'b0;
            out_idx       <= '0;
            src           <= '0;
            rem           <= '0;
            sampled_words <= '0;
        end else begin
            state_q <= state_d;
            done    <= last;
            if (load) begin
                out_idx <= '0;
                src     <= '0;
                rem     <= '0;
            end else if (write) begin
                sampled_words[out_idx] <= frame_words[src];
                if (!last) begin
                    out_idx <= out_idx + IDX_W'(1);
                    src     <= src_next;
                    rem     <= rem_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_sampler.sv
// -----------------------------------------------------------------------------
// tb_frame_sampler
//
// Self-checking bench for frame_sampler. Four instances with different
// geometries (16->5 decimation, 4->8 upsample, 8->8 identity, 7->1) share one
// frame bus and reset; a select index chooses which instance is started and
// observed. Expected results come from a reference model that evaluates
// floor(i*IN/OUT) directly and tracks which slots should already have been
// overwritten at every cycle of a run.
// -----------------------------------------------------------------------------
module tb_frame_sampler;

    localparam int DW = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] frame_bus;
    logic [3:0]   start_v;

    logic [DW*5-1:0] sampled_a;
    logic [DW*8-1:0] sampled_b;
    logic [DW*8-1:0] sampled_c;
    logic [DW*1-1:0] sampled_d;
    logic [3:0]      busy_v;
    logic [3:0]      done_v;

    int sel;
    int checks = 0;
    int errors = 0;

    int ic_tab [4] = '{16, 4, 8, 7};
    int oc_tab [4] = '{5, 8, 8, 1};
    logic [255:0] prev_tab [4];

    logic [255:0] obs_sampled;
    logic         obs_busy;
    logic         obs_done;

    always #5 clk = ~clk;

    frame_sampler #(.INPUT_COUNT(16), .OUTPUT_COUNT(5), .DATA_WIDTH(DW)) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .frame_flat(frame_bus[DW*16-1:0]),
        .sampled_flat(sampled_a), .busy(busy_v[0]), .done(done_v[0]));

    frame_sampler #(.INPUT_COUNT(4), .OUTPUT_COUNT(8), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .frame_flat(frame_bus[DW*4-1:0]),
        .sampled_flat(sampled_b), .busy(busy_v[1]), .done(done_v[1]));

    frame_sampler #(.INPUT_COUNT(8), .OUTPUT_COUNT(8), .DATA_WIDTH(DW)) dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .frame_flat(frame_bus[DW*8-1:0]),
        .sampled_flat(sampled_c), .busy(busy_v[2]), .done(done_v[2]));

    frame_sampler #(.INPUT_COUNT(7), .OUTPUT_COUNT(1), .DATA_WIDTH(DW)) dut_d (
        .clk(clk), .rst(rst), .start(start_v[3]), .frame_flat(frame_bus[DW*7-1:0]),
        .sampled_flat(sampled_d), .busy(busy_v[3]), .done(done_v[3]));

    // Route the selected instance onto a common observation bus.
    always_comb begin
        obs_sampled = '0;
        case (sel)
            0: obs_sampled = 256'(sampled_a);
            1: obs_sampled = 256'(sampled_b);
            2: obs_sampled = 256'(sampled_c);
            default: obs_sampled = 256'(sampled_d);
        endcase
        obs_busy = busy_v[sel[1:0]];
        obs_done = done_v[sel[1:0]];
    end

    // Reference model: slots below nw hold frame word floor(s*ic/oc),
    // the rest still hold whatever the previous run left behind.
    function automatic logic [255:0] modelVec(logic [255:0] f, logic [255:0] p,
                                              int ic, int oc, int nw);
        logic [255:0] v;
        v = '0;
        for (int s = 0; s < oc; s++) begin
            if (s < nw) v[s*DW +: DW] = f[((s * ic) / oc) * DW +: DW];
            else        v[s*DW +: DW] = p[s*DW +: DW];
        end
        return v;
    endfunction

    function automatic logic [255:0] ramp(int base, int n);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < n; k++) f[k*DW +: DW] = DW'(base + k);
        return f;
    endfunction

    function automatic logic [255:0] randFrame();
        logic [255:0] f;
        for (int w = 0; w < 8; w++) f[w*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on the selected instance; returns at the falling edge
    // right after the accepting edge.
    task automatic applyStimulus(input logic [255:0] frame);
        frame_bus = frame;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v = '0;
    endtask

    // Follow one run from the first busy cycle to the done pulse, checking
    // slot progression each cycle. restart_n re-pulses start at that RUN
    // cycle (negative: never).
    task automatic runAndCheck(input string tag, input int restart_n);
        int ic, oc, n, busy_cnt;
        logic [255:0] prev;
        ic       = ic_tab[sel];
        oc       = oc_tab[sel];
        prev     = prev_tab[sel];
        n        = 0;
        busy_cnt = 0;
        while (!obs_done && n < oc + 4) begin
            if (obs_busy) busy_cnt++;
            checkOutput({tag, "/progress"}, obs_sampled, modelVec(frame_bus, prev, ic, oc, n));
            checkOutput({tag, "/busy"}, 256'(obs_busy), 256'(n < oc));
            start_v[sel] = (n == restart_n);
            @(negedge clk);
            n++;
        end
        start_v = '0;
        checkOutput({tag, "/done_seen"}, 256'(obs_done), 256'(1));
        checkOutput({tag, "/done_cycle"}, 256'(n), 256'(oc));
        checkOutput({tag, "/busy_cycles"}, 256'(busy_cnt), 256'(oc));
        checkOutput({tag, "/busy_at_done"}, 256'(obs_busy), 256'(0));
        checkOutput({tag, "/result"}, obs_sampled, modelVec(frame_bus, prev, ic, oc, oc));
        prev_tab[sel] = modelVec(frame_bus, prev, ic, oc, oc);
    endtask

    task automatic checkIdleAfter(input string tag);
        @(negedge clk);
        checkOutput({tag, "/done_pulse_end"}, 256'(obs_done), 256'(0));
        checkOutput({tag, "/idle_busy"}, 256'(obs_busy), 256'(0));
        checkOutput({tag, "/result_held"}, obs_sampled, prev_tab[sel]);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int rs;
        rst       = 1'b1;
        start_v   = '0;
        frame_bus = '0;
        sel       = 0;
        for (int i = 0; i < 4; i++) prev_tab[i] = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            checkOutput("reset/sampled", obs_sampled, 256'(0));
            checkOutput("reset/busy", 256'(obs_busy), 256'(0));
            checkOutput("reset/done", 256'(obs_done), 256'(0));
        end
        rst = 1'b0;

        $display("[TB] ramp decimation 16->5");
        sel = 0;
        applyStimulus(ramp(0, 16));
        runAndCheck("ramp", -1);
        checkOutput("ramp/expected", obs_sampled, 256'({16'd12, 16'd9, 16'd6, 16'd3, 16'd0}));
        checkIdleAfter("ramp");

        $display("[TB] start ignored while busy, then back-to-back");
        applyStimulus(ramp(0, 16));
        runAndCheck("ignore", 2);
        frame_bus    = ramp(100, 16);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v = '0;
        runAndCheck("b2b", -1);
        checkOutput("b2b/expected", obs_sampled, 256'({16'd112, 16'd109, 16'd106, 16'd103, 16'd100}));
        checkIdleAfter("b2b");

        $display("[TB] reset mid-run");
        applyStimulus(randFrame());
        repeat (3) @(negedge clk);
        checkOutput("midrst/partial", obs_sampled,
                    modelVec(frame_bus, prev_tab[0], 16, 5, 3));
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst/sampled", obs_sampled, 256'(0));
        checkOutput("midrst/busy", 256'(obs_busy), 256'(0));
        checkOutput("midrst/done", 256'(obs_done), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) prev_tab[i] = '0;
        applyStimulus(randFrame());
        runAndCheck("afterrst", -1);
        checkIdleAfter("afterrst");

        $display("[TB] upsample, identity, single output");
        sel = 1;
        applyStimulus(ramp(1, 4));
        runAndCheck("upsample", -1);
        checkOutput("upsample/expected", obs_sampled,
                    256'({16'd4, 16'd4, 16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1}));
        checkIdleAfter("upsample");
        sel = 2;
        applyStimulus(ramp(16'hA0, 8));
        runAndCheck("identity", -1);
        checkOutput("identity/expected", obs_sampled, ramp(16'hA0, 8));
        checkIdleAfter("identity");
        sel = 3;
        applyStimulus(randFrame());
        runAndCheck("single", -1);
        checkIdleAfter("single");

        $display("[TB] randomized runs");
        for (int it = 0; it < 12; it++) begin
            sel = int'($urandom_range(3, 0));
            rs  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(oc_tab[sel] - 1, 0)) : -1;
            applyStimulus(randFrame());
            runAndCheck("random", rs);
            if ($urandom_range(1, 0) == 1) begin
                frame_bus    = randFrame();
                start_v[sel] = 1'b1;
                @(negedge clk);
                start_v = '0;
                runAndCheck("random_b2b", -1);
            end
            checkIdleAfter("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sampler.md
# frame_sampler

Sequential decimating sampler that picks OUTPUT_COUNT words out of a flat INPUT_COUNT-word frame by nearest-lower (floor) index mapping. It sits between the frame/pixel buffer and downstream compute (e.g. the generator/discriminator input stage), and reduces a full frame to a fixed-size vector. A start/busy/done handshake controls operation, and the block produces one output word per clock.

## Interface
- INPUT_COUNT, 784: number of words in `frame_flat`; must be ≥1.
- OUTPUT_COUNT, 196: number of words in `sampled_flat`; must be ≥1. It may exceed INPUT_COUNT, in which case source words repeat.
- DATA_WIDTH, 16: bits per word; words are treated as opaque bit patterns.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  single-cycle request; sampled on the rising edge; honoured only in IDLE.
- frame_flat  in  DATA_WIDTH*INPUT_COUNT  source frame; word k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- sampled_flat  out  DATA_WIDTH*OUTPUT_COUNT  registered result, same packing.
- busy  out  1  high while sampling is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- Mapping: sampled word i = frame word floor(i*INPUT_COUNT/OUTPUT_COUNT), for i = 0..OUTPUT_COUNT-1.
- No runtime divider. Use elaboration-time constants Q = INPUT_COUNT/OUTPUT_COUNT and R = INPUT_COUNT%OUTPUT_COUNT.
- Maintain the source index `src` and remainder `rem`. At each step, add Q to `src` and R to `rem`. If `rem` ≥ OUTPUT_COUNT, subtract OUTPUT_COUNT from `rem` and add 1 to `src`.
- Counters are sized with $clog2 of the respective counts, plus one bit of headroom for `rem`.
- State machine:
  - IDLE: when start=1, load out_idx=0, src=0, rem=0, set busy=1, and go to RUN.
  - RUN: each cycle, write frame word `src` into sampled slot `out_idx`, then advance the counters. On the cycle that writes slot OUTPUT_COUNT-1, set busy=0 and done=1, and return to IDLE.
- `frame_flat` is read live and must be held stable by the producer while busy=1. The block does not snapshot it.
- `sampled_flat` slots are overwritten progressively during RUN and hold their final values from the done pulse until the next accepted start.
- A start while busy=1 is ignored, with no effect on the counters or outputs.
- A start in the same cycle that done=1 is accepted, because the state is IDLE by then.

## Timing
- Reset (asynchronous, any time): state=IDLE, busy=0, done=0, sampled_flat=0, counters=0. A reset during RUN aborts the run, and partial results are cleared.
- Edge E0 samples start=1 in IDLE. busy is high from after E0 through the edge that writes the last slot, i.e. for exactly OUTPUT_COUNT cycles.
- Slot i is written at edge E0+1+i.
- done is high for exactly one cycle, beginning after edge E0+OUTPUT_COUNT. busy and done are never high simultaneously.
- Total latency from the start edge to done asserted is OUTPUT_COUNT cycles. The result is valid while done=1 and afterwards.
- With OUTPUT_COUNT=1, busy is high for one cycle, slot 0 receives frame word 0, and done follows.

## Test plan
- Ramp decimation: INPUT_COUNT=16, OUTPUT_COUNT=5, DATA_WIDTH=16, frame word k = k, one start pulse. Required response: sampled = {0,3,6,9,12} (index 0 first), busy high for 5 cycles, done a single-cycle pulse.
- Identity: INPUT_COUNT=OUTPUT_COUNT=8, word k = 0xA0+k. Required response: sampled word k = 0xA0+k, with done 8 cycles after start.
- Upsample: INPUT_COUNT=4, OUTPUT_COUNT=8, word k = k+1. Required response: sampled = {1,1,2,2,3,3,4,4}.
- Start ignored while busy: using the 16→5 ramp, re-pulse start at cycle 2 of RUN. Required response: still exactly one done, 5 cycles after the first start, with result {0,3,6,9,12}.
- Reset mid-run: assert rst at RUN cycle 3. Required response: busy=0, done=0, and sampled_flat=0 immediately (asynchronously). After release, a new start yields the correct full result.
- Back-to-back runs: change the frame to word k = 100+k and pulse start in the done cycle. Required response: second result {100,103,106,109,112}, with the first result held until the second run's slots overwrite it.
